ray_axis2fifo_pack: RTL and testbench

Parametrised AXI4-Stream-to-FIFO bridge that packs `BEATS` consecutive narrow stream beats into one `DATA_WIDTH*BEATS`-bit record and writes it into a first-word-fall-through-agnostic FIFO write port. It sits between a narrow DMA stream (e.g. 64-bit) and the 256-bit ray FIFO that feeds the traversal core.

- Provides a registered output stage and backpressure from FIFO `full`.
- Enforces record framing against `tlast` and `tkeep`.
- Keeps sticky error flags and a written-record counter.

---
 rtl/ray_axis2fifo_pack.sv | 90 +++++++++
 tb/tb_ray_axis2fifo_pack.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ray_axis2fifo_pack.sv
// rtl/ray_axis2fifo_pack.sv - packs BEATS narrow AXI4-Stream beats into one record for a FIFO write port
module ray_axis2fifo_pack #(
  parameter int DATA_WIDTH = 64,
  parameter int BEATS      = 4
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]       s_axis_tkeep,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          full,
  output logic [DATA_WIDTH*BEATS-1:0]   din,
  output logic                          write,
  input  logic                          clr_err,
  output logic                          err_short,
  output logic                          err_keep,
  output logic [31:0]                   rec_count
);
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);

  logic [CW-1:0]                cnt;
  logic                         out_valid;
  logic                         accept;
  logic                         at_last;
  logic                         set_short;
  logic                         set_keep;
  logic [DATA_WIDTH*BEATS-1:0]  rec_next;

  assign at_last   = (cnt == LAST_IDX);
  assign write     = out_valid & ~full;
  // Only the record-completing beat needs a free output register; earlier beats land in staging.
  assign s_axis_tready = aresetn & (~at_last | ~out_valid | ~full);
  assign accept    = s_axis_tvalid & s_axis_tready;
  assign set_short = accept & ~at_last & s_axis_tlast;
  assign set_keep  = accept & ~(&s_axis_tkeep);

  generate
    if (BEATS > 1) begin : g_stage
      logic [BEATS-2:0][DATA_WIDTH-1:0] stage;

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          stage <= '0;
        end else if (accept && !at_last) begin
          for (int i = 0; i < BEATS - 1; i++) begin
            if (cnt == CW'(i)) stage[i] <= s_axis_tdata;
          end
        end
      end

      assign rec_next = {s_axis_tdata, stage};
    end else begin : g_nostage
      assign rec_next = s_axis_tdata;
    end
  endgenerate

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt       <= '0;
      out_valid <= 1'b0;
      din       <= '0;
      rec_count <= '0;
      err_short <= 1'b0;
      err_keep  <= 1'b0;
    end else begin
      if (accept) begin
        if (at_last) begin
          din <= rec_next;
          cnt <= '0;
        end else if (s_axis_tlast) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      // A load in the same cycle as a drain keeps the register full with the new record.
      if (accept && at_last) out_valid <= 1'b1;
      else if (write)        out_valid <= 1'b0;

      if (write) rec_count <= rec_count + 32'd1;

      err_short <= set_short | (err_short & ~clr_err);
      err_keep  <= set_keep  | (err_keep  & ~clr_err);
    end
  end
endmodule

// File: tb/tb_ray_axis2fifo_pack.sv
// tb/tb_ray_axis2fifo_pack.sv - self-checking bench for ray_axis2fifo_pack with a queue-based reference model
module tb_ray_axis2fifo_pack;
  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [63:0]  s_tdata = '0;
  logic [7:0]   s_tkeep = 8'hFF;
  logic         s_tlast = 1'b0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic         full = 1'b0;
  logic [255:0] din;
  logic         write;
  logic         clr_err = 1'b0;
  logic         err_short, err_keep;
  logic [31:0]  rec_count;

  logic [63:0]  b_tdata = '0;
  logic         b_tvalid = 1'b0;
  logic         b_tready;
  logic [63:0]  b_din;
  logic         b_write;
  logic         b_err_short, b_err_keep;
  logic [31:0]  b_count;

  int errors = 0;
  int checks = 0;
  bit rand_full = 1'b0;

  logic [63:0]  part_q[$];
  logic [255:0] exp_q[$];
  logic [255:0] got_q[$];
  bit           m_short = 1'b0;
  bit           m_keep = 1'b0;
  int           m_total = 0;
  logic [255:0] m_rec;
  bit           m_ss, m_sk;

  always #5 aclk = ~aclk;

  ray_axis2fifo_pack #(.DATA_WIDTH(64), .BEATS(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .full(full), .din(din), .write(write), .clr_err(clr_err),
    .err_short(err_short), .err_keep(err_keep), .rec_count(rec_count)
  );

  ray_axis2fifo_pack #(.DATA_WIDTH(64), .BEATS(1)) dut1 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(b_tdata), .s_axis_tkeep(8'hFF), .s_axis_tlast(1'b0),
    .s_axis_tvalid(b_tvalid), .s_axis_tready(b_tready),
    .full(1'b0), .din(b_din), .write(b_write), .clr_err(1'b0),
    .err_short(b_err_short), .err_keep(b_err_keep), .rec_count(b_count)
  );

  // Reference model: gather accepted beats, emit a record every 4, drop partial packets on tlast.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (write) got_q.push_back(din);
      m_ss = 1'b0;
      m_sk = 1'b0;
      if (s_tvalid && s_tready) begin
        if (s_tkeep != 8'hFF) m_sk = 1'b1;
        part_q.push_back(s_tdata);
        if (part_q.size() == 4) begin
          for (int i = 0; i < 4; i++) m_rec[i*64 +: 64] = part_q[i];
          exp_q.push_back(m_rec);
          m_total++;
          part_q.delete();
        end else if (s_tlast) begin
          part_q.delete();
          m_ss = 1'b1;
        end
      end
      m_short = m_ss | (m_short & ~clr_err);
      m_keep  = m_sk | (m_keep & ~clr_err);
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    s_tvalid = 1'b0;
    b_tvalid = 1'b0;
    full = 1'b0;
    clr_err = 1'b0;
    tick();
    tick();
    part_q.delete();
    exp_q.delete();
    got_q.delete();
    m_short = 1'b0;
    m_keep = 1'b0;
    m_total = 0;
    aresetn = 1'b1;
  endtask

  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l);
    int n = 0;
    s_tdata = d;
    s_tkeep = k;
    s_tlast = l;
    s_tvalid = 1'b1;
    @(negedge aclk);
    while (!s_tready && n < 64) begin
      tick();
      if (rand_full) full = ($urandom_range(0, 2) == 0);
      n++;
      @(negedge aclk);
    end
    if (!s_tready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: tready=%0b required 1", s_tready);
    end
    tick();
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    if (rand_full) full = ($urandom_range(0, 3) == 0);
  endtask

  task automatic test_reset();
    s_tvalid = 1'b1;
    tick();
    tick();
    @(negedge aclk);
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %0b exp 0", s_tready); end
    checks++; if (write !== 1'b0) begin errors++; $display("FAIL reset_write: got %0b exp 0", write); end
    checks++; if (din !== 256'd0) begin errors++; $display("FAIL reset_din: got %h exp 0", din); end
    checks++; if (rec_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", rec_count); end
    checks++; if ({err_short, err_keep} !== 2'b00) begin errors++; $display("FAIL reset_errs: got %b exp 00", {err_short, err_keep}); end
    checks++; if (b_tready !== 1'b0) begin errors++; $display("FAIL reset_b1_tready: got %0b exp 0", b_tready); end
    tick();
    s_tvalid = 1'b0;
    aresetn = 1'b1;
    @(negedge aclk);
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL release_tready: got %0b exp 1", s_tready); end
    tick();
  endtask

  task automatic test_basic();
    logic [255:0] exp_rec;
    do_reset();
    send({8{8'h11}}, 8'hFF, 1'b0);
    send({8{8'h22}}, 8'hFF, 1'b0);
    send({8{8'h33}}, 8'hFF, 1'b0);
    send({8{8'h44}}, 8'hFF, 1'b1);
    exp_rec = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
    @(negedge aclk);
    checks++; if (write !== 1'b1) begin errors++; $display("FAIL basic_write_latency: got %0b exp 1", write); end
    checks++; if (din !== exp_rec) begin errors++; $display("FAIL basic_din: got %h exp %h", din, exp_rec); end
    tick();
    @(negedge aclk);
    checks++; if (write !== 1'b0) begin errors++; $display("FAIL basic_single_write: got %0b exp 0", write); end
    checks++; if (rec_count !== 32'd1) begin errors++; $display("FAIL basic_count: got %0d exp 1", rec_count); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [63:0] d[8];
    logic [255:0] r1, r2;
    do_reset();
    full = 1'b1;
    for (int i = 0; i < 8; i++) d[i] = {$urandom, $urandom};
    r1 = {d[3], d[2], d[1], d[0]};
    r2 = {d[7], d[6], d[5], d[4]};
    for (int i = 0; i < 8; i++) begin
      s_tdata = d[i];
      s_tkeep = 8'hFF;
      s_tvalid = 1'b1;
      @(negedge aclk);
      checks++; if (s_tready !== (i != 7)) begin errors++; $display("FAIL bp_tready_beat%0d: got %0b exp %0b", i, s_tready, i != 7); end
      checks++; if (write !== 1'b0) begin errors++; $display("FAIL bp_no_write_beat%0d: got %0b exp 0", i, write); end
      if (i < 7) tick();
    end
    for (int j = 0; j < 2; j++) begin
      tick();
      @(negedge aclk);
      checks++; if ({s_tready, write} !== 2'b00) begin errors++; $display("FAIL bp_stall: tready,write got %b exp 00", {s_tready, write}); end
    end
    tick();
    full = 1'b0;
    @(negedge aclk);
    checks++; if ({s_tready, write} !== 2'b11) begin errors++; $display("FAIL bp_release: tready,write got %b exp 11", {s_tready, write}); end
    checks++; if (din !== r1) begin errors++; $display("FAIL bp_rec1: got %h exp %h", din, r1); end
    tick();
    s_tvalid = 1'b0;
    @(negedge aclk);
    checks++; if (write !== 1'b1) begin errors++; $display("FAIL bp_write2: got %0b exp 1", write); end
    checks++; if (din !== r2) begin errors++; $display("FAIL bp_rec2: got %h exp %h", din, r2); end
    tick();
    @(negedge aclk);
    checks++; if (write !== 1'b0) begin errors++; $display("FAIL bp_idle: got %0b exp 0", write); end
    checks++; if (rec_count !== 32'd2) begin errors++; $display("FAIL bp_count: got %0d exp 2", rec_count); end
    tick();
  endtask

  task automatic test_short_packet();
    logic [63:0] e[4];
    do_reset();
    send(64'hAAAA_0000_0000_0000, 8'hFF, 1'b0);
    send(64'hAAAA_0000_0000_0001, 8'hFF, 1'b0);
    send(64'hAAAA_0000_0000_0002, 8'hFF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      e[i] = {$urandom, $urandom};
      send(e[i], 8'hFF, i == 3);
    end
    repeat (3) tick();
    @(negedge aclk);
    checks++; if (err_short !== 1'b1) begin errors++; $display("FAIL short_flag: got %0b exp 1", err_short); end
    checks++; if (err_keep !== 1'b0) begin errors++; $display("FAIL short_keep_clean: got %0b exp 0", err_keep); end
    checks++; if (rec_count !== 32'd1) begin errors++; $display("FAIL short_count: got %0d exp 1", rec_count); end
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL short_nwrites: got %0d exp 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== {e[3], e[2], e[1], e[0]}) begin errors++; $display("FAIL short_record: got %h exp %h", got_q[0], {e[3], e[2], e[1], e[0]}); end
    end
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    @(negedge aclk);
    checks++; if (err_short !== 1'b0) begin errors++; $display("FAIL short_clear: got %0b exp 0", err_short); end
    tick();
  endtask

  task automatic test_keep_error();
    logic [63:0] e[4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      e[i] = {$urandom, $urandom};
      send(e[i], (i == 1) ? 8'h0F : 8'hFF, 1'b0);
    end
    repeat (2) tick();
    @(negedge aclk);
    checks++; if (err_keep !== 1'b1) begin errors++; $display("FAIL keep_flag: got %0b exp 1", err_keep); end
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL keep_nwrites: got %0d exp 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== {e[3], e[2], e[1], e[0]}) begin errors++; $display("FAIL keep_raw_data: got %h exp %h", got_q[0], {e[3], e[2], e[1], e[0]}); end
    end
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    @(negedge aclk);
    checks++; if (err_keep !== 1'b0) begin errors++; $display("FAIL keep_clear: got %0b exp 0", err_keep); end
    tick();
    clr_err = 1'b1;
    send(64'h1234, 8'hF0, 1'b0);
    clr_err = 1'b0;
    @(negedge aclk);
    checks++; if (err_keep !== 1'b1) begin errors++; $display("FAIL keep_set_beats_clear: got %0b exp 1", err_keep); end
    tick();
  endtask

  task automatic test_mid_reset();
    logic [63:0] e[4];
    do_reset();
    full = 1'b1;
    for (int i = 0; i < 6; i++) send({$urandom, $urandom}, 8'hFF, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      e[i] = {$urandom, $urandom};
      send(e[i], 8'hFF, 1'b0);
    end
    repeat (2) tick();
    @(negedge aclk);
    checks++; if (rec_count !== 32'd1) begin errors++; $display("FAIL midreset_count: got %0d exp 1", rec_count); end
    checks++; if (din !== {e[3], e[2], e[1], e[0]}) begin errors++; $display("FAIL midreset_record: got %h exp %h", din, {e[3], e[2], e[1], e[0]}); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    rand_full = 1'b1;
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        clr_err = ($urandom_range(0, 4) == 0);
        tick();
        clr_err = 1'b0;
        full = ($urandom_range(0, 2) == 0);
      end
      send({$urandom, $urandom},
           ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hFF,
           $urandom_range(0, 5) == 0);
    end
    rand_full = 1'b0;
    full = 1'b0;
    repeat (4) tick();
    @(negedge aclk);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_nrecords: got %0d exp %0d", got_q.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_record%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
      end
    end
    checks++; if (rec_count !== 32'(m_total)) begin errors++; $display("FAIL rand_count: got %0d exp %0d", rec_count, m_total); end
    checks++; if (err_short !== m_short) begin errors++; $display("FAIL rand_err_short: got %0b exp %0b", err_short, m_short); end
    checks++; if (err_keep !== m_keep) begin errors++; $display("FAIL rand_err_keep: got %0b exp %0b", err_keep, m_keep); end
    tick();
  endtask

  task automatic test_count_wrap();
    do_reset();
    force dut.rec_count = 32'hFFFF_FFFF;
    @(negedge aclk);
    release dut.rec_count;
    tick();
    for (int i = 0; i < 4; i++) send({$urandom, $urandom}, 8'hFF, 1'b0);
    @(negedge aclk);
    checks++; if (write !== 1'b1) begin errors++; $display("FAIL wrap_write: got %0b exp 1", write); end
    tick();
    @(negedge aclk);
    checks++; if (rec_count !== 32'd0) begin errors++; $display("FAIL wrap_count: got %h exp 0", rec_count); end
    tick();
  endtask

  task automatic test_beats1();
    logic [63:0] cur, prev;
    do_reset();
    prev = '0;
    b_tvalid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cur = {$urandom, $urandom};
      b_tdata = cur;
      @(negedge aclk);
      checks++; if (b_tready !== 1'b1) begin errors++; $display("FAIL b1_tready%0d: got %0b exp 1", i, b_tready); end
      if (i > 0) begin
        checks++; if ({b_write, b_din} !== {1'b1, prev}) begin errors++; $display("FAIL b1_write%0d: got %0b/%h exp 1/%h", i, b_write, b_din, prev); end
      end
      prev = cur;
      tick();
    end
    b_tvalid = 1'b0;
    @(negedge aclk);
    checks++; if ({b_write, b_din} !== {1'b1, prev}) begin errors++; $display("FAIL b1_last_write: got %0b/%h exp 1/%h", b_write, b_din, prev); end
    tick();
    @(negedge aclk);
    checks++; if (b_write !== 1'b0) begin errors++; $display("FAIL b1_idle: got %0b exp 0", b_write); end
    checks++; if (b_count !== 32'd16) begin errors++; $display("FAIL b1_count: got %0d exp 16", b_count); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_short_packet();
    test_keep_error();
    test_mid_reset();
    test_random();
    test_count_wrap();
    test_beats1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
